// File: rtl/paddle_input_conditioner.sv
// Paddle button front end: 2-flop synchronisers, per-button debounce FSMs with
// hold-to-repeat, and left/right conflict resolution into one-cycle move pulses.
module paddle_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_left_n,
  input  logic btn_right_n,
  output logic left_level,
  output logic right_level,
  output logic move_left,
  output logic move_right
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } db_state_t;

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Index 0 is the left button, index 1 the right button throughout.
  logic [1:0]       sync_meta, sync_out;
  db_state_t        state_q [2];
  db_state_t        state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [CNT_W-1:0] rcnt_q  [2];
  logic [CNT_W-1:0] rcnt_d  [2];
  logic [1:0]       first_q, first_d;
  logic [1:0]       event_d;
  logic [1:0]       level_q, level_d;
  logic [1:0]       move_q, move_d;

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      rcnt_d[i]  = rcnt_q[i];
      first_d[i] = first_q[i];
      event_d[i] = 1'b0;

      unique case (state_q[i])
        RELEASED: begin
          if (!sync_out[i]) begin
            state_d[i] = PRESS_CHK;
            cnt_d[i]   = '0;
          end
        end
        PRESS_CHK: begin
          if (sync_out[i]) begin
            state_d[i] = RELEASED;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i] = PRESSED;
            event_d[i] = 1'b1;
            rcnt_d[i]  = '0;
            first_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (sync_out[i]) begin
            state_d[i] = RELEASE_CHK;
            cnt_d[i]   = '0;
          end else if (rcnt_q[i] == (first_q[i] ? DELAY_LAST : PERIOD_LAST)) begin
            event_d[i] = 1'b1;
            rcnt_d[i]  = '0;
            first_d[i] = 1'b0;
          end else begin
            rcnt_d[i] = rcnt_q[i] + CNT_ONE;
          end
        end
        RELEASE_CHK: begin
          // A release that bounces back restarts the initial repeat delay.
          if (!sync_out[i]) begin
            state_d[i] = PRESSED;
            rcnt_d[i]  = '0;
            first_d[i] = 1'b1;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i] = RELEASED;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: state_d[i] = RELEASED;
      endcase

      level_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_CHK);
    end

    // Events are suppressed while the opposite bar is held; counters keep running.
    move_d[0] = event_d[0] & ~level_d[1];
    move_d[1] = event_d[1] & ~level_d[0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 2'b11;
      sync_out  <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
        rcnt_q[i]  <= '0;
      end
      first_q <= '0;
      level_q <= '0;
      move_q  <= '0;
    end else begin
      sync_meta <= {btn_right_n, btn_left_n};
      sync_out  <= sync_meta;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
      first_q <= first_d;
      level_q <= level_d;
      move_q  <= move_d;
    end
  end

  assign left_level  = level_q[0];
  assign right_level = level_q[1];
  assign move_left   = move_q[0];
  assign move_right  = move_q[1];

endmodule

// File: doc/paddle_input_conditioner.md
Name: paddle_input_conditioner

Overview:
Upstream stage for the paddle game's display/game-logic block. It turns the two raw, active-low, bouncing paddle buttons into clean signals:
- debounced active-high levels;
- single-cycle move pulses with hold-to-repeat, which the game logic consumes as bar move requests.

It owns synchronisation, debounce, auto-repeat and left/right conflict resolution, so downstream logic sees only clean, mutually exclusive move requests.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples needed to accept a press or a release (10 ms at 50 MHz); must be >= 2.
REPEAT_DELAY, 25000000, cycles a button is held after its accepted press before the first auto-repeat pulse; >= 2.
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses; >= 2.
CNT_W, 25, width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
btn_left_n  input  1  raw left button, asynchronous, low = pressed.
btn_right_n  input  1  raw right button, asynchronous, low = pressed.
left_level  output  1  debounced left state, 1 = held.
right_level  output  1  debounced right state, 1 = held.
move_left  output  1  one-cycle move request, left.
move_right  output  1  one-cycle move request, right.

Behaviour:
- Reset (rst=1 at a clk edge):
  - sync flops load 1 (released);
  - both debounce FSMs go to RELEASED;
  - all counters clear to 0;
  - all four outputs are 0 from the next cycle.
  - A button held through reset must be debounced again as a fresh press.
- Synchronisation: each raw input passes a 2-flop synchroniser. "Sample" below means the second flop's output. Pressed = sample==0.
- Per-button debounce FSM. The two FSMs are identical and independent. Each has one counter, cnt.
  - RELEASED: level=0. Sample pressed -> PRESS_CHK with cnt=0.
  - PRESS_CHK: level=0.
    - Sample released -> RELEASED (bounce rejected).
    - Else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED and raise a press event.
    - Else cnt+1.
  - PRESSED: level=1.
    - Sample released -> RELEASE_CHK with cnt=0.
    - Otherwise run the repeat logic.
  - RELEASE_CHK: level stays 1.
    - Sample pressed -> PRESSED, continuing without a new press event.
    - Else if cnt==DEBOUNCE_CYCLES-1 -> RELEASED.
    - Else cnt+1.
  - The level output is registered from the state.
  - Timing: the raw input falls before edge N and stays stable. Then the level is 1 in the cycle after edge N+2+DEBOUNCE_CYCLES. Release has the same latency.
- Repeat, per button:
  - E = the edge that enters PRESSED from PRESS_CHK; the press event occurs at E.
  - Repeat events occur at E+REPEAT_DELAY, then every REPEAT_PERIOD edges after that while the FSM remains in PRESSED.
  - A PRESSED->RELEASE_CHK->PRESSED excursion resets the repeat counter and restarts the REPEAT_DELAY interval, with no event on re-entry.
- Move pulses (registered, one cycle wide):
  - move_left = left event (press or repeat) AND NOT right_level_next.
  - move_right is symmetric.
  - _next means the level value being registered on the same edge.
  - If both buttons are held, or both accept presses on the same edge, no move pulses are issued.
  - Repeat counters keep running while pulses are suppressed, so pulses resume on the repeat grid once the other button is released.
- move_left and move_right are never 1 in the same cycle.

Test Plan:
Parameter overrides for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Clean press. Drive btn_left_n low before edge 0 and hold it.
   -> left_level rises after edge 6.
   -> move_left=1 for exactly the cycle after edge 6.
   -> right_level, move_right stay 0.
2. Bounce rejection. btn_left_n low for 3 edges, high for 2, repeated 5 times.
   -> left_level and move_left stay 0 throughout.
3. Auto-repeat. Hold left with press accepted at edge E.
   -> move_left pulses after E, E+10, E+13, E+16.
   -> Release: left_level falls 6 edges after the raw rise.
   -> No pulses after release.
4. Conflict. Right held and debounced; then left pressed.
   -> left_level=1, no move_left, no move_right while both are held.
   -> Release right: after right_level falls, the next left repeat on the grid yields move_left.
5. Simultaneous press. Both raw inputs fall before the same edge.
   -> Both levels rise on the same edge.
   -> No move pulses for 30 cycles while both are held.
6. Reset mid-operation. Assert rst for 1 cycle while left is held and repeating.
   -> All outputs 0 the next cycle.
   -> With left still held, left_level re-rises exactly 6 edges after rst deasserts, with a fresh move_left.
